// File: rtl/smpl_sequencer_if.sv
// Handshake/bus bundle between the sample sequencer, the ADC and the downstream sample register bank.
interface smpl_sequencer_if #(
  parameter int DATA_WIDTH = 12,
  parameter int N          = 14
);
  logic                  start;
  logic                  adc_valid;
  logic [DATA_WIDTH-1:0] adc_data;
  logic                  adc_start;
  logic [N-1:0]          enables;
  logic [DATA_WIDTH-1:0] out_smpl;
  logic                  busy;
  logic                  frame_done;
  logic                  err;

  modport master (
    output start, adc_valid, adc_data,
    input  adc_start, enables, out_smpl, busy, frame_done, err
  );

  modport slave (
    input  start, adc_valid, adc_data,
    output adc_start, enables, out_smpl, busy, frame_done, err
  );
endinterface

// File: rtl/smpl_sequencer.sv
// Frame sequencer: converts N ADC samples per frame and strobes each into a one-hot slot of a register bank.
// Optional WAIT timeout with sticky err is enabled by defining SMPL_SEQ_TIMEOUT_EN.
//
//   state     | meaning
//   ST_IDLE   | no frame; waiting for start
//   ST_CONV   | one-cycle adc_start pulse for the current slot
//   ST_WAIT   | waiting for adc_valid (or timeout)
//   ST_WRITE  | one-hot enable for the current slot, out_smpl valid
//   ST_SETTLE | SETTLE idle cycles before the next conversion
module smpl_sequencer #(
  parameter int DATA_WIDTH = 12,
  parameter int N          = 14,
  parameter int SETTLE     = 4,
  parameter int TIMEOUT    = 255
) (
  input logic             clk,
  input logic             rst,
  smpl_sequencer_if.slave bus
);

  localparam int SLOT_W   = (N > 1) ? $clog2(N) : 1;
  localparam int SET_W    = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam int SET_LD_I = (SETTLE > 0) ? SETTLE - 1 : 0;
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(N - 1);
  localparam logic [SET_W-1:0]  SET_LD    = SET_W'(SET_LD_I);
  localparam logic [N-1:0]      EN_ONE    = N'(1);

  if (N < 1 || DATA_WIDTH < 1 || SETTLE < 0 || TIMEOUT < 1) begin : g_param_check
    $error("smpl_sequencer: invalid parameter value");
  end

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CONV,
    ST_WAIT,
    ST_WRITE,
    ST_SETTLE
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [SLOT_W-1:0]     r_slot;
  logic [SET_W-1:0]      r_set_cnt;
  logic                  r_adc_start;
  logic [N-1:0]          r_enables;
  logic [DATA_WIDTH-1:0] r_out_smpl;
  logic                  r_busy;
  logic                  r_frame_done;
  logic                  w_tmo_hit;
  logic                  w_tmo_fire;

  always_comb begin
    w_state_nxt = r_state;
    w_tmo_fire  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) w_state_nxt = ST_CONV;
      end
      ST_CONV: begin
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.adc_valid) begin
          w_state_nxt = ST_WRITE;
        end else if (w_tmo_hit) begin
          w_state_nxt = ST_WRITE;
          w_tmo_fire  = 1'b1;
        end
      end
      ST_WRITE: begin
        if (r_slot == SLOT_LAST) w_state_nxt = ST_IDLE;
        else if (SETTLE > 0)     w_state_nxt = ST_SETTLE;
        else                     w_state_nxt = ST_CONV;
      end
      ST_SETTLE: begin
        if (r_set_cnt == '0) w_state_nxt = ST_CONV;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_slot       <= '0;
      r_set_cnt    <= '0;
      r_adc_start  <= 1'b0;
      r_enables    <= '0;
      r_out_smpl   <= '0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_adc_start  <= (w_state_nxt == ST_CONV);
      r_busy       <= (w_state_nxt != ST_IDLE);
      r_enables    <= (w_state_nxt == ST_WRITE) ? (EN_ONE << r_slot) : '0;
      r_frame_done <= (w_state_nxt == ST_WRITE) && (r_slot == SLOT_LAST);

      if (r_state == ST_IDLE && w_state_nxt == ST_CONV)
        r_slot <= '0;
      else if (r_state == ST_WRITE && r_slot != SLOT_LAST)
        r_slot <= r_slot + 1'b1;

      if (r_state == ST_WAIT && bus.adc_valid)
        r_out_smpl <= bus.adc_data;
      else if (w_tmo_fire)
        r_out_smpl <= '1;

      if (r_state == ST_WRITE && w_state_nxt == ST_SETTLE)
        r_set_cnt <= SET_LD;
      else if (r_state == ST_SETTLE && r_set_cnt != '0)
        r_set_cnt <= r_set_cnt - 1'b1;
    end
  end

`ifdef SMPL_SEQ_TIMEOUT_EN
  localparam int TMO_W    = $clog2(TIMEOUT + 1);
  localparam int TMO_LD_I = TIMEOUT - 1;
  localparam logic [TMO_W-1:0] TMO_LD = TMO_W'(TMO_LD_I);

  logic [TMO_W-1:0] r_tmo_cnt;
  logic             r_err;

  assign w_tmo_hit = (r_tmo_cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tmo_cnt <= '0;
      r_err     <= 1'b0;
    end else begin
      if (r_state == ST_CONV)
        r_tmo_cnt <= TMO_LD;
      else if (r_state == ST_WAIT && !w_tmo_hit)
        r_tmo_cnt <= r_tmo_cnt - 1'b1;
      if (w_tmo_fire)
        r_err <= 1'b1;
    end
  end

  assign bus.err = r_err;
`else
  assign w_tmo_hit = 1'b0;
  assign bus.err   = 1'b0;
`endif

  assign bus.adc_start  = r_adc_start;
  assign bus.enables    = r_enables;
  assign bus.out_smpl   = r_out_smpl;
  assign bus.busy       = r_busy;
  assign bus.frame_done = r_frame_done;

endmodule

// File: tb/tb_smpl_sequencer.sv
// Directed bench for smpl_sequencer: dut_a uses SETTLE=4, dut_b uses SETTLE=0; both N=14, 12-bit samples.
module tb_smpl_sequencer;
  localparam int DW = 12;
  localparam int NS = 14;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  smpl_sequencer_if #(.DATA_WIDTH(DW), .N(NS)) a_if ();
  smpl_sequencer_if #(.DATA_WIDTH(DW), .N(NS)) b_if ();

  smpl_sequencer #(.DATA_WIDTH(DW), .N(NS), .SETTLE(4), .TIMEOUT(255)) dut_a (
    .clk(clk), .rst(rst), .bus(a_if.slave));
  smpl_sequencer #(.DATA_WIDTH(DW), .N(NS), .SETTLE(0), .TIMEOUT(255)) dut_b (
    .clk(clk), .rst(rst), .bus(b_if.slave));

  int checks = 0;
  int errors = 0;

  int            a_idx = 0;
  int            a_cnt = 0;
  int            a_mute = -1;
  bit            a_spur = 1'b0;
  logic [DW-1:0] a_spur_data = 12'hABC;
  int            b_idx = 0;
  int            b_cnt = 0;

  // ADC models: answer each adc_start with valid 3 cycles later, data 0x100 + conversion index.
  initial begin
    a_if.adc_valid = 1'b0;
    a_if.adc_data  = '0;
    forever begin
      @(posedge clk); #1;
      a_if.adc_valid = 1'b0;
      if (a_if.busy === 1'b0) begin a_idx = 0; a_cnt = 0; end
      if (a_cnt > 0) begin
        a_cnt--;
        if (a_cnt == 0) begin
          if (a_idx != a_mute) begin
            a_if.adc_valid = 1'b1;
            a_if.adc_data  = DW'(12'h100 + a_idx);
          end
          a_idx++;
        end
      end
      if (a_if.adc_start === 1'b1) a_cnt = 2;
      if (a_spur) begin
        a_if.adc_valid = 1'b1;
        a_if.adc_data  = a_spur_data;
      end
    end
  end

  initial begin
    b_if.adc_valid = 1'b0;
    b_if.adc_data  = '0;
    forever begin
      @(posedge clk); #1;
      b_if.adc_valid = 1'b0;
      if (b_if.busy === 1'b0) begin b_idx = 0; b_cnt = 0; end
      if (b_cnt > 0) begin
        b_cnt--;
        if (b_cnt == 0) begin
          b_if.adc_valid = 1'b1;
          b_if.adc_data  = DW'(12'h100 + b_idx);
          b_idx++;
        end
      end
      if (b_if.adc_start === 1'b1) b_cnt = 2;
    end
  end

  task automatic wait_en_a(input int lim, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < lim && !seen; i++) begin
      @(negedge clk);
      if (a_if.enables !== '0) seen = 1'b1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    a_if.start = 1'b0;
    b_if.start = 1'b0;
    #2;
    checks++;
    if ({a_if.adc_start, a_if.enables, a_if.out_smpl, a_if.busy, a_if.frame_done, a_if.err} !== '0) begin
      errors++;
      $display("FAIL reset_a_outputs got en=%h smpl=%h busy=%b exp all 0", a_if.enables, a_if.out_smpl, a_if.busy);
    end
    repeat (3) @(negedge clk);
    checks++;
    if ({b_if.adc_start, b_if.enables, b_if.out_smpl, b_if.busy, b_if.frame_done, b_if.err} !== '0) begin
      errors++;
      $display("FAIL reset_b_outputs got en=%h smpl=%h busy=%b exp all 0", b_if.enables, b_if.out_smpl, b_if.busy);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (a_if.busy !== 1'b0 || a_if.adc_start !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_start got busy=%b adc_start=%b exp 0 0", a_if.busy, a_if.adc_start);
    end
  endtask

  task automatic test_full_frame;
    bit seen;
    logic [NS-1:0] exp_en;
    a_if.start = 1'b1;
    @(negedge clk);
    a_if.start = 1'b0;
    checks++;
    if (a_if.adc_start !== 1'b1 || a_if.busy !== 1'b1) begin
      errors++;
      $display("FAIL start_latency got adc_start=%b busy=%b exp 1 1", a_if.adc_start, a_if.busy);
    end
    for (int s = 0; s < NS; s++) begin
      wait_en_a(40, seen);
      exp_en = '0;
      exp_en[s] = 1'b1;
      checks++;
      if (!seen || a_if.enables !== exp_en) begin
        errors++;
        $display("FAIL frame_en slot %0d got %h exp %h", s, a_if.enables, exp_en);
      end
      checks++;
      if (a_if.out_smpl !== DW'(12'h100 + s)) begin
        errors++;
        $display("FAIL frame_smpl slot %0d got %h exp %h", s, a_if.out_smpl, 12'h100 + s);
      end
      checks++;
      if (a_if.frame_done !== (s == NS - 1)) begin
        errors++;
        $display("FAIL frame_done slot %0d got %b exp %b", s, a_if.frame_done, s == NS - 1);
      end
      if (s < NS - 1) begin
        if (s == 5) a_if.start = 1'b1;
        for (int k = 1; k <= 5; k++) begin
          @(negedge clk);
          if (s == 3 && k == 1) a_spur = 1'b1;
          if (k == 2) begin a_spur = 1'b0; a_if.start = 1'b0; end
          checks++;
          if (k < 5) begin
            if (a_if.adc_start !== 1'b0 || a_if.enables !== '0 || a_if.out_smpl !== DW'(12'h100 + s)) begin
              errors++;
              $display("FAIL settle slot %0d cyc %0d got adc_start=%b en=%h smpl=%h exp 0 0 %h",
                       s, k, a_if.adc_start, a_if.enables, a_if.out_smpl, 12'h100 + s);
            end
          end else if (a_if.adc_start !== 1'b1) begin
            errors++;
            $display("FAIL settle_len slot %0d got adc_start=%b exp 1", s, a_if.adc_start);
          end
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    bit seen;
    @(negedge clk);
    checks++;
    if (a_if.busy !== 1'b0 || a_if.frame_done !== 1'b0 || a_if.enables !== '0) begin
      errors++;
      $display("FAIL frame_end got busy=%b done=%b en=%h exp 0 0 0", a_if.busy, a_if.frame_done, a_if.enables);
    end
    a_if.start = 1'b1;
    @(negedge clk);
    a_if.start = 1'b0;
    checks++;
    if (a_if.adc_start !== 1'b1) begin
      errors++;
      $display("FAIL b2b_adc_start got %b exp 1", a_if.adc_start);
    end
    wait_en_a(40, seen);
    checks++;
    if (!seen || a_if.enables !== 14'h0001 || a_if.out_smpl !== 12'h100) begin
      errors++;
      $display("FAIL b2b_slot0 got en=%h smpl=%h exp 0001 100", a_if.enables, a_if.out_smpl);
    end
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (a_if.frame_done === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen || a_if.enables !== 14'h2000 || a_if.out_smpl !== 12'h10D) begin
      errors++;
      $display("FAIL b2b_done got seen=%b en=%h smpl=%h exp 1 2000 10d", seen, a_if.enables, a_if.out_smpl);
    end
  endtask

  task automatic test_idle_spurious;
    @(negedge clk);
    a_spur = 1'b1;
    @(negedge clk);
    a_spur = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (a_if.enables !== '0 || a_if.out_smpl !== 12'h10D || a_if.busy !== 1'b0) begin
        errors++;
        $display("FAIL idle_spur cyc %0d got en=%h smpl=%h busy=%b exp 0 10d 0",
                 k, a_if.enables, a_if.out_smpl, a_if.busy);
      end
    end
  endtask

  task automatic test_settle_zero;
    bit seen;
    logic [NS-1:0] exp_en;
    b_if.start = 1'b1;
    @(negedge clk);
    b_if.start = 1'b0;
    for (int s = 0; s < NS; s++) begin
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
        @(negedge clk);
        if (b_if.enables !== '0) seen = 1'b1;
      end
      exp_en = '0;
      exp_en[s] = 1'b1;
      checks++;
      if (!seen || b_if.enables !== exp_en || b_if.out_smpl !== DW'(12'h100 + s)) begin
        errors++;
        $display("FAIL s0_slot %0d got en=%h smpl=%h exp %h %h", s, b_if.enables, b_if.out_smpl, exp_en, 12'h100 + s);
      end
      @(negedge clk);
      checks++;
      if (b_if.adc_start !== (s < NS - 1)) begin
        errors++;
        $display("FAIL s0_next_conv slot %0d got adc_start=%b exp %b", s, b_if.adc_start, s < NS - 1);
      end
    end
    checks++;
    if (b_if.busy !== 1'b0) begin
      errors++;
      $display("FAIL s0_idle got busy=%b exp 0", b_if.busy);
    end
  endtask

  task automatic test_reset_mid_frame;
    bit seen;
    bit bad;
    a_if.start = 1'b1;
    @(negedge clk);
    a_if.start = 1'b0;
    for (int s = 0; s < 7; s++) wait_en_a(40, seen);
    checks++;
    if (!seen || a_if.enables !== 14'h0040) begin
      errors++;
      $display("FAIL rst_mid_slot6 got en=%h exp 0040", a_if.enables);
    end
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (a_if.adc_start === 1'b1) seen = 1'b1;
    end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (!seen || {a_if.adc_start, a_if.enables, a_if.out_smpl, a_if.busy, a_if.frame_done, a_if.err} !== '0) begin
      errors++;
      $display("FAIL rst_mid_outputs got seen=%b en=%h smpl=%h busy=%b exp 1 0 0 0",
               seen, a_if.enables, a_if.out_smpl, a_if.busy);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (a_if.enables !== '0 || a_if.frame_done !== 1'b0 || a_if.busy !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL rst_mid_quiet got activity=%b exp 0", bad);
    end
    a_if.start = 1'b1;
    @(negedge clk);
    a_if.start = 1'b0;
    wait_en_a(40, seen);
    checks++;
    if (!seen || a_if.enables !== 14'h0001 || a_if.out_smpl !== 12'h100) begin
      errors++;
      $display("FAIL rst_mid_restart got en=%h smpl=%h exp 0001 100", a_if.enables, a_if.out_smpl);
    end
  endtask

  task automatic test_timeout;
    bit seen;
    bit bad;
    int k;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    a_mute = 2;
    a_if.start = 1'b1;
    @(negedge clk);
    a_if.start = 1'b0;
    wait_en_a(40, seen);
    wait_en_a(40, seen);
    checks++;
    if (!seen || a_if.enables !== 14'h0002 || a_if.out_smpl !== 12'h101) begin
      errors++;
      $display("FAIL tmo_slot1 got en=%h smpl=%h exp 0002 101", a_if.enables, a_if.out_smpl);
    end
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (a_if.adc_start === 1'b1) seen = 1'b1;
    end
    k = 0;
    bad = 1'b0;
`ifdef SMPL_SEQ_TIMEOUT_EN
    while (k < 400 && a_if.enables === '0) begin
      if (a_if.err !== 1'b0) bad = 1'b1;
      @(negedge clk);
      k++;
    end
    checks++;
    if (!seen || bad || k != 256) begin
      errors++;
      $display("FAIL tmo_wait_len got cycles=%0d early_err=%b exp 256 0", k, bad);
    end
    checks++;
    if (a_if.enables !== 14'h0004 || a_if.out_smpl !== 12'hFFF || a_if.err !== 1'b1) begin
      errors++;
      $display("FAIL tmo_fire got en=%h smpl=%h err=%b exp 0004 fff 1", a_if.enables, a_if.out_smpl, a_if.err);
    end
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (a_if.frame_done === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen || a_if.enables !== 14'h2000 || a_if.err !== 1'b1) begin
      errors++;
      $display("FAIL tmo_frame_done got seen=%b en=%h err=%b exp 1 2000 1", seen, a_if.enables, a_if.err);
    end
`else
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (a_if.enables !== '0 || a_if.busy !== 1'b1 || a_if.err !== 1'b0) bad = 1'b1;
      k++;
    end
    checks++;
    if (!seen || bad) begin
      errors++;
      $display("FAIL tmo_disabled_wait got seen=%b left_wait=%b exp 1 0", seen, bad);
    end
`endif
    a_mute = -1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (a_if.err !== 1'b0 || a_if.busy !== 1'b0) begin
      errors++;
      $display("FAIL tmo_rst_clear got err=%b busy=%b exp 0 0", a_if.err, a_if.busy);
    end
  endtask

  initial begin
    test_reset;
    test_full_frame;
    test_back_to_back;
    test_idle_spurious;
    test_settle_zero;
    test_reset_mid_frame;
    test_timeout;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/smpl_sequencer.md
SMPL_SEQUENCER -- requirements
Module: smpl_sequencer

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 12, giving the sample width in bits.
REQ-002 The block SHALL have parameter N, default 14, giving the number of sample slots per frame.
REQ-003 The block SHALL have parameter SETTLE, default 4, giving the idle cycles between slots (0 allowed).
REQ-004 The block SHALL have parameter TIMEOUT, default 255, giving the maximum WAIT cycles (used only under REQ-027).
REQ-005 Port clk, input, 1 bit: the single clock; all logic SHALL be on its rising edge.
REQ-006 Port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-007 Port start, input, 1 bit: frame request, sampled on the clock edge.
REQ-008 Port adc_valid, input, 1 bit: the ADC result is valid this cycle.
REQ-009 Port adc_data, input, DATA_WIDTH bits: the ADC conversion result.
REQ-010 Port adc_start, output, 1 bit: a one-cycle conversion-start pulse.
REQ-011 Port enables, output, N bits: one-hot slot write strobe for the downstream sample register bank.
REQ-012 Port out_smpl, output, DATA_WIDTH bits: the sample presented with enables.
REQ-013 Port busy, output, 1 bit: high while a frame is in progress.
REQ-014 Port frame_done, output, 1 bit: a one-cycle pulse when the frame completes.
REQ-015 Port err, output, 1 bit: sticky timeout flag.

Function
REQ-016 All outputs SHALL be registered, and the FSM SHALL use exactly the states IDLE, CONV, WAIT, WRITE and SETTLE.
REQ-017 IDLE: start=1 SHALL load slot=0, set busy=1 and go to CONV; start=0 SHALL keep the FSM in IDLE.
REQ-018 CONV: adc_start SHALL be 1 for exactly this cycle, then the FSM SHALL go to WAIT; adc_start SHALL rise in the cycle after start is sampled.
REQ-019 WAIT: adc_valid=1 SHALL capture adc_data into out_smpl and go to WRITE; adc_valid in any other state SHALL be ignored.
REQ-020 WRITE: enables SHALL equal 1<<slot for exactly one cycle, with out_smpl stable over that cycle; enables SHALL be all-zero in every other state.
REQ-021 WRITE with slot<N-1: slot SHALL increment, then the FSM SHALL go to SETTLE if SETTLE>0, else to CONV.
REQ-022 WRITE with slot==N-1: frame_done SHALL pulse in the same cycle as the final enable, and next state SHALL be IDLE with busy=0; slot SHALL NOT wrap within a frame.
REQ-023 SETTLE: the FSM SHALL stay exactly SETTLE cycles, then go to CONV.
REQ-024 start while busy SHALL be ignored (no queuing); start asserted in the IDLE-entry cycle after frame_done SHALL begin a new frame.
REQ-025 The slot counter SHALL be ceil(log2(N)) bits wide (minimum 1), and the SETTLE/TIMEOUT counters SHALL be wide enough to hold their parameter value.
REQ-026 out_smpl SHALL hold its last value between writes.

Configuration
REQ-027 With macro SMPL_SEQ_TIMEOUT_EN defined, a WAIT lasting TIMEOUT cycles without adc_valid SHALL set err=1, load out_smpl with all-ones and go to WRITE, and the frame SHALL continue.
REQ-028 Without SMPL_SEQ_TIMEOUT_EN, WAIT SHALL wait indefinitely, err SHALL be constant 0, and no timeout counter SHALL be synthesized.
REQ-029 err SHALL clear only on rst.

Reset
REQ-030 On rst=1, the block SHALL immediately set state=IDLE, slot=0 and all counters to 0.
REQ-031 On rst=1, the outputs SHALL be: adc_start=0, enables=0, out_smpl=0, busy=0, frame_done=0, err=0.
REQ-032 rst mid-frame SHALL abort the frame with no further enables or frame_done; the first activity after release SHALL require a new start.

Verification
REQ-033 Full frame (N=14, SETTLE=4): start pulse; ADC answers each adc_start after 3 cycles with data 0x100+slot -> enables 0x0001..0x2000 in order, each one cycle with out_smpl=0x100+slot; frame_done coincides with enables=0x2000.
REQ-034 SETTLE=0: the next adc_start SHALL occur the cycle after each WRITE, giving a 14-slot frame with no gaps beyond the ADC latency.
REQ-035 start pulsed at slot 5 mid-frame -> no effect; start in the cycle after frame_done -> adc_start the next cycle, slot 0 again.
REQ-036 Spurious adc_valid=1 during SETTLE and IDLE -> no enables and out_smpl unchanged.
REQ-037 rst asserted during WAIT of slot 7 -> all outputs 0 within the same cycle; no frame_done; a later start restarts at slot 0.
REQ-038 With SMPL_SEQ_TIMEOUT_EN and TIMEOUT=255: ADC silent at slot 2 -> after 255 WAIT cycles err=1, enables=0x0004 with out_smpl=0xFFF, and the frame completes; without the macro, the FSM stays in WAIT and err=0.
